// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
//
// Direct-mapped branch predictor with a small branch target table and a 2-bit
// saturating direction counter per entry. The fetch-stage lookup is purely
// combinational. Resolved branches from execute update the table on the
// rising clock edge. The unit also produces the execute-stage misprediction
// redirect and keeps a saturating count of mispredictions.
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   rst            synchronous active-high reset
//   PCF            fetch PC being looked up
//   PredTakenF     predicted taken for PCF
//   PredTargetF    predicted target for PCF (entry target on hit, else 0)
//   EnE            execute stage holds a valid, unstalled instruction
//   BranchE        execute instruction is a conditional branch
//   TakenE         resolved branch outcome
//   PCE            PC of the execute instruction
//   BranchTargetE  resolved branch target
//   PredTakenE     prediction made for this instruction at fetch
//   PredTargetE    predicted target carried down the pipeline
//   MispredictE    flush / redirect request
//   CorrectPCE     redirect PC (resolved target if taken, else PCE+4)
//   MissCount      saturating misprediction counter
// -----------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int ENTRIES = 8,
    parameter int IDXW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        EnE,
    input  logic        BranchE,
    input  logic        TakenE,
    input  logic [31:0] PCE,
    input  logic [31:0] BranchTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] CorrectPCE,
    output logic [15:0] MissCount
);

    localparam int TAGW = 30 - IDXW;

    // Table storage
    logic [ENTRIES-1:0] valid;
    logic [TAGW-1:0]    tag_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];
    logic [1:0]         ctr_mem    [ENTRIES];

    logic [IDXW-1:0] idx_f;
    logic [IDXW-1:0] idx_e;
    logic [TAGW-1:0] tag_f;
    logic [TAGW-1:0] tag_e;
    logic            hit_f;
    logic            hit_e;
    logic            update;
    logic            target_diff;

    // Instructions are word aligned, so the two low fetch PC bits carry no
    // information for indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^PCF[1:0];

    // Two-bit saturating counter step: taken moves toward 11, not-taken
    // toward 00.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

    // Fetch lookup
    assign idx_f = PCF[IDXW+1:2];
    assign tag_f = PCF[31:IDXW+2];
    assign hit_f = valid[idx_f] && (tag_mem[idx_f] == tag_f);

    assign PredTakenF  = hit_f && ctr_mem[idx_f][1];
    assign PredTargetF = hit_f ? target_mem[idx_f] : 32'd0;

    // Execute resolution
    assign idx_e  = PCE[IDXW+1:2];
    assign tag_e  = PCE[31:IDXW+2];
    assign hit_e  = valid[idx_e] && (tag_mem[idx_e] == tag_e);
    assign update = EnE && BranchE;

    // A correctly predicted taken branch still needs a redirect when the
    // target it was fetched toward is not the resolved one.
    assign target_diff = TakenE && PredTakenE && (BranchTargetE != PredTargetE);
    assign MispredictE = update && ((TakenE != PredTakenE) || target_diff);
    assign CorrectPCE  = TakenE ? BranchTargetE : (PCE + 32'd4);

    // Table update. Writes land on the clock edge, so a fetch lookup of the
    // entry being updated in the same cycle sees the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]      <= 1'b0;
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
                ctr_mem[i]    <= 2'b01;
            end
        end else if (update) begin
            if (hit_e) begin
                ctr_mem[idx_e] <= ctr_step(ctr_mem[idx_e], TakenE);
                if (TakenE) target_mem[idx_e] <= BranchTargetE;
            end else if (TakenE) begin
                // Allocate on a taken miss, evicting whatever aliased here.
                valid[idx_e]      <= 1'b1;
                tag_mem[idx_e]    <= tag_e;
                target_mem[idx_e] <= BranchTargetE;
                ctr_mem[idx_e]    <= 2'b10;
            end
        end
    end

    // Misprediction counter, held at all-ones once saturated
    always_ff @(posedge clk) begin
        if (rst) begin
            MissCount <= 16'd0;
        end else if (MispredictE && (MissCount != 16'hFFFF)) begin
            MissCount <= MissCount + 16'd1;
        end
    end

endmodule
